dsm_cic_decoder: RTL and testbench
==================================

Name: dsm_cic_decoder

Overview:
- Receive-side decoder for a 1-bit delta-sigma bitstream on dsm_in.
- Reconstructs a signed width-bit PCM sample stream using an N-stage CIC (sinc^N) decimator with decimation ratio R = 2^LOG2R.
- Output feeds the same signed sample path as the FIR filters (dout1..dout4 in the sub-tops).

Parameters:
- width, 16, output sample width (signed)
- N, 3, CIC order (integrator and comb stage count)
- LOG2R, 6, log2 of the decimation ratio R (default R=64)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- cke  input  1  bitstream sample enable; state advances only when high
- dsm_in  input  1  delta-sigma bit; 1 maps to +1, 0 maps to -1
- dout  output  width  signed decoded sample
- dout_valid  output  1  one-cycle strobe marking a new dout

Behaviour:
- Reset (rst=0, async) clears:
  - all integrators, comb delay registers and the decimation counter to 0
  - dout to 0 and dout_valid to 0
- Reset asserted mid-frame discards any partial frame. The first frame after release is a full R enabled cycles.
- Internal width WI = N*LOG2R + 2 (signed).
  - Integrators use two's-complement wrap-around, no saturation. Wrap is required for CIC correctness.
- Per cycle with cke=1:
  - x = +1 if dsm_in else -1
  - I1 += x, Ik += I(k-1) for k=2..N; all integrators update in the same cycle (registered cascade)
  - cnt increments modulo R
- Decimation strobe: cke=1 and cnt==R-1 in the same cycle.
  - IN is sampled after that cycle's update.
  - The combs run once on the decimated sample: Ck = C(k-1) - C(k-1)_prev, with C0 = IN, and each _prev register updated.
- Output timing:
  - dout/dout_valid are registered; they update on the clock edge after the strobe.
  - dout_valid=1 for exactly one cycle per R enabled input cycles.
- Latency:
  - strobe to dout_valid: 1 cycle
  - group delay: N*(R-1)/2 input samples
- Scaling: full-scale CN = ±R^N = ±2^(N*LOG2R).
  - dout = saturate(CN >>> (N*LOG2R+1-width)) to [-2^(width-1), 2^(width-1)-1].
  - With the defaults, all-ones input gives +32768, which saturates to 32767; all-zeros gives -32768.
  - Elaboration error if N*LOG2R+1 < width.
- cke=0 freezes integrators, combs and cnt. A dout_valid already scheduled from a strobe still fires.
- Startup transient: the first N-1 valid outputs after reset are partial. Output index N-1 onward is steady-state.
- dout holds its value between strobes.

Decomposition:
- Package dsm_pkg: function clog-free constants WI(N,LOG2R), OUT_SHIFT = N*LOG2R+1-width, saturation limits, and a sat_shift function.
- One sub-module, cic_integrator: single WI-bit wrapping accumulator with cke and async active-low clear, instantiated N times via generate.
- Combs stay inline in dsm_cic_decoder.

Test Plan:
- Constant 1s for 8*R enabled cycles -> dout_valid every 64 cycles; outputs index 3 onward = 32767.
- Constant 0s -> outputs index 3 onward = -32768.
- Alternating 1,0 pattern -> outputs index 3 onward = 0.
- Bitstream from a first-order DSM of a 0.25-full-scale DC input -> steady-state dout within ±64 of 8192.
- cke toggled 50% random -> output sequence identical to the cke=1 run; valid spacing equals 64 enabled cycles.
- rst pulsed low mid-frame (cnt=30), asynchronously -> dout=0 and dout_valid=0 immediately; first post-reset valid exactly 64 enabled cycles + 1 after release.

Source files
------------

// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - sizing constants and output saturation helpers for the CIC decoder
package dsm_pkg;

  function automatic int calc_wi(input int n, input int log2r);
    return n * log2r + 2;
  endfunction

  function automatic int calc_out_shift(input int n, input int log2r, input int w);
    return n * log2r + 1 - w;
  endfunction

  function automatic logic signed [63:0] sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Arithmetic shift then clamp to a signed w-bit range; callers truncate to w bits.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] v,
                                                   input int shift, input int w);
    logic signed [63:0] s;
    s = v >>> shift;
    if (s > sat_hi(w)) return sat_hi(w);
    if (s < sat_lo(w)) return sat_lo(w);
    return s;
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// rtl/cic_integrator.sv - one wrapping CIC integrator stage with enable and async clear
module cic_integrator #(
  parameter int WI = 20
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cke,
  input  logic signed [WI-1:0] i_din,
  output logic signed [WI-1:0] o_acc,
  output logic signed [WI-1:0] o_acc_next
);

  logic signed [WI-1:0] r_acc;

  // Two's-complement wrap is intentional; the comb differences undo it.
  assign o_acc_next = r_acc + i_din;
  assign o_acc      = r_acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_acc <= '0;
    else if (i_cke) r_acc <= o_acc_next;
  end

endmodule

// File: rtl/dsm_cic_decoder.sv
// rtl/dsm_cic_decoder.sv - sinc^N decimator turning a 1-bit delta-sigma stream into signed PCM
module dsm_cic_decoder
  import dsm_pkg::*;
#(
  parameter int width = 16,
  parameter int N     = 3,
  parameter int LOG2R = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cke,
  input  logic                    dsm_in,
  output logic signed [width-1:0] dout,
  output logic                    dout_valid
);

  localparam int WI        = calc_wi(N, LOG2R);
  localparam int OUT_SHIFT = calc_out_shift(N, LOG2R, width);

  if (OUT_SHIFT < 0) begin : g_bad_width
    $error("dsm_cic_decoder: N*LOG2R+1 must be at least width");
  end

  logic [LOG2R-1:0]        r_cnt;
  logic signed [WI-1:0]    r_comb_prev [N];
  logic signed [width-1:0] r_dout;
  logic                    r_dout_valid;

  logic                    w_strobe;
  logic signed [WI-1:0]    w_x;
  logic signed [WI-1:0]    w_int_in   [N];
  logic signed [WI-1:0]    w_int_acc  [N];
  logic signed [WI-1:0]    w_int_next [N];
  logic signed [WI-1:0]    w_comb     [N+1];
  logic signed [width-1:0] w_dout;

  assign w_strobe = cke && (&r_cnt);
  assign w_x      = dsm_in ? {{(WI-1){1'b0}}, 1'b1} : {WI{1'b1}};

  for (genvar k = 0; k < N; k++) begin : g_int
    if (k == 0) begin : g_first
      assign w_int_in[k] = w_x;
    end else begin : g_rest
      assign w_int_in[k] = w_int_acc[k-1];
    end
    cic_integrator #(.WI(WI)) u_int (
      .i_clk      (clk),
      .i_rst_n    (rst),
      .i_cke      (cke),
      .i_din      (w_int_in[k]),
      .o_acc      (w_int_acc[k]),
      .o_acc_next (w_int_next[k])
    );
  end

  // Combs see the last integrator's post-update value, so the strobe cycle's bit is included.
  always_comb begin
    w_comb[0] = w_int_next[N-1];
    for (int k = 0; k < N; k++) begin
      w_comb[k+1] = w_comb[k] - r_comb_prev[k];
    end
  end

  assign w_dout = width'(sat_shift(64'(w_comb[N]), OUT_SHIFT, width));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_comb_prev  <= '{default: '0};
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_strobe;
      if (cke) r_cnt <= r_cnt + LOG2R'(1);
      if (w_strobe) begin
        for (int k = 0; k < N; k++) r_comb_prev[k] <= w_comb[k];
        r_dout <= w_dout;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_dsm_cic_decoder.sv
// tb/tb_dsm_cic_decoder.sv - directed self-checking bench for dsm_cic_decoder
module tb_dsm_cic_decoder;

  logic               clk;
  logic               rst;
  logic               cke;
  logic               dsm_in;
  logic signed [15:0] dout;
  logic               dout_valid;

  int n_tests;
  int n_fail;
  int en_cnt;
  int outs[$];
  int gaps[$];

  dsm_cic_decoder #(.width(16), .N(3), .LOG2R(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .cke        (cke),
    .dsm_in     (dsm_in),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic d, input logic c);
    cke    = c;
    dsm_in = d;
    @(posedge clk);
    #1;
    if (c) en_cnt++;
    if (dout_valid) begin
      outs.push_back(int'(dout));
      gaps.push_back(en_cnt);
      en_cnt = 0;
    end
  endtask

  task automatic do_reset();
    cke = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    en_cnt = 0;
    outs.delete();
    gaps.delete();
  endtask

  task automatic check_run(input string tag, input int e0, input int e1, input int ess);
    int exp;
    check({tag, "_count"}, outs.size(), 8);
    for (int i = 0; i < 8; i++) begin
      exp = (i == 0) ? e0 : (i == 1) ? e1 : ess;
      check($sformatf("%s_out%0d", tag, i), outs[i], exp);
      check($sformatf("%s_gap%0d", tag, i), gaps[i], 64);
    end
  endtask

  initial begin
    int v;
    int k;
    int d;
    logic b;
    n_tests = 0;
    n_fail  = 0;
    en_cnt  = 0;
    cke     = 1'b0;
    dsm_in  = 1'b0;
    rst     = 1'b0;
    #2;
    check("reset_dout", int'(dout), 0);
    check("reset_valid", int'(dout_valid), 0);

    do_reset();
    for (int t = 0; t < 512; t++) cyc(1'b1, 1'b1);
    check_run("ones", 5208, 27048, 32767);

    // Leave the counter at 30 into a fresh frame, then reset between clock edges.
    for (int t = 0; t < 30; t++) cyc(1'b1, 1'b1);
    check("hold_dout", int'(dout), 32767);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_dout", int'(dout), 0);
    check("async_rst_valid", int'(dout_valid), 0);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    en_cnt = 0;
    outs.delete();
    gaps.delete();
    for (int t = 0; t < 512; t++) cyc(1'b0, 1'b1);
    check_run("zeros", -5208, -27048, -32768);

    do_reset();
    for (int t = 0; t < 512; t++) cyc(~t[0], 1'b1);
    check_run("alt", 124, 132, 0);

    do_reset();
    v = 0;
    for (int t = 0; t < 512; t++) begin
      b = (v >= 0);
      v = v + 1 - (b ? 4 : -4);
      cyc(b, 1'b1);
    end
    check("dsm_count", outs.size(), 8);
    for (int i = 3; i < 8; i++) begin
      d = outs[i] - 8192;
      n_tests++;
      assert ((d >= -64) && (d <= 64)) else begin
        n_fail++;
        $error("FAIL dsm_out%0d observed=%0d expected=8192+-64", i, outs[i]);
      end
    end

    do_reset();
    k = 0;
    for (int t = 0; (t < 4000) && (k < 512); t++) begin
      b = 1'($urandom_range(0, 1));
      cyc(~k[0], b);
      if (b) k++;
    end
    check("rand_enabled", k, 512);
    check_run("rand_cke", 124, 132, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
